// File: rtl/cache_sched_pkg.sv
// rtl/cache_sched_pkg.sv - shared types and constants for the cache access scheduler
package cache_sched_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    ACC_READ  = 2'd0,
    ACC_WRITE = 2'd1,
    ACC_INVAL = 2'd2,
    ACC_IDLE  = 2'd3
  } acc_type_e;

  typedef enum logic {
    S_RUN,
    S_PAUSE
  } sched_state_e;

endpackage

// File: rtl/cache_access_scheduler_if.sv
// rtl/cache_access_scheduler_if.sv - requester/snoop handshakes and cache-side issue bus
interface cache_access_scheduler_if #(
  parameter int NUM_REQ = 4
);
  import cache_sched_pkg::*;

  localparam int SRC_W = $clog2(NUM_REQ + 1);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*2-1:0]      req_type;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      snp_valid;
  logic [ADDR_W-1:0]         snp_addr;
  logic                      snp_ready;
  logic [1:0]                Access_type;
  logic [ADDR_W-1:0]         Hex_address;
  logic                      issue_valid;
  logic [SRC_W-1:0]          issue_src;
  logic [31:0]               issue_count;

  modport master (
    output req_valid, req_type, req_addr, snp_valid, snp_addr,
    input  req_ready, snp_ready, Access_type, Hex_address, issue_valid, issue_src, issue_count
  );

  modport slave (
    input  req_valid, req_type, req_addr, snp_valid, snp_addr,
    output req_ready, snp_ready, Access_type, Hex_address, issue_valid, issue_src, issue_count
  );

endinterface

// File: rtl/cache_access_scheduler_rr.sv
// rtl/cache_access_scheduler_rr.sv - round-robin arbiter searching upward from ptr_i with wrap
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = W'(j);
      end
    end
  end

endmodule

// File: rtl/cache_access_scheduler.sv
// rtl/cache_access_scheduler.sv - one-access-per-cycle cache port shared by requesters and snoop
module cache_access_scheduler
  import cache_sched_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pause_i,
  cache_access_scheduler_if.slave bus
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int SRC_W  = $clog2(NUM_REQ + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  sched_state_e      state_q;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  acc_type_e         acc_q, acc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [SRC_W-1:0]  src_q, src_d;
  logic [31:0]       count_q, count_d;

  logic [NUM_REQ-1:0] rr_gnt;
  logic [PTR_W-1:0]   rr_idx;
  logic               rr_any;
  logic               run, snp_gnt, req_gnt;
  logic [1:0]         sel_type;
  logic [ADDR_W-1:0]  sel_addr;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx),
    .any_o (rr_any)
  );

  // A snoop still wins after starving requesters if no requester is actually waiting.
  assign run      = rst_n && !pause_i && (state_q == S_RUN);
  assign snp_gnt  = run && bus.snp_valid && ((wait_cnt_q < WAIT_W'(MAX_WAIT)) || !rr_any);
  assign req_gnt  = run && !snp_gnt && rr_any;
  assign sel_type = bus.req_type[{rr_idx, 1'b0} +: 2];
  assign sel_addr = bus.req_addr[rr_idx * ADDR_W +: ADDR_W];

  assign bus.snp_ready   = snp_gnt;
  assign bus.req_ready   = req_gnt ? rr_gnt : '0;
  assign bus.Access_type = acc_q;
  assign bus.Hex_address = addr_q;
  assign bus.issue_valid = valid_q;
  assign bus.issue_src   = src_q;
  assign bus.issue_count = count_q;

  always_comb begin
    acc_d      = ACC_IDLE;
    valid_d    = 1'b0;
    addr_d     = addr_q;
    src_d      = src_q;
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    if (snp_gnt) begin
      acc_d   = ACC_INVAL;
      addr_d  = bus.snp_addr;
      valid_d = 1'b1;
      src_d   = SRC_W'(NUM_REQ);
      if (rr_any && (wait_cnt_q < WAIT_W'(MAX_WAIT))) wait_cnt_d = wait_cnt_q + 1'b1;
    end else if (req_gnt) begin
      // An illegal type is consumed from the requester but never reaches the cache.
      if (sel_type != 2'b11) begin
        acc_d   = acc_type_e'(sel_type);
        addr_d  = sel_addr;
        valid_d = 1'b1;
        src_d   = SRC_W'(rr_idx);
      end
      rr_ptr_d   = (int'(rr_idx) == NUM_REQ - 1) ? '0 : rr_idx + 1'b1;
      wait_cnt_d = '0;
    end
    count_d = count_q + {31'd0, valid_d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      rr_ptr_q   <= '0;
      wait_cnt_q <= '0;
      acc_q      <= ACC_IDLE;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      src_q      <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= pause_i ? S_PAUSE : S_RUN;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      acc_q      <= acc_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      src_q      <= src_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_cache_access_scheduler.sv
// tb/tb_cache_access_scheduler.sv - scoreboard bench for cache_access_scheduler
module tb_cache_access_scheduler;

  localparam int NR = 4;
  localparam int MW = 8;

  typedef struct {
    logic        v;
    logic [1:0]  t;
    logic [31:0] a;
    logic [2:0]  s;
    logic [31:0] c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pause = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  exp_t        sb[$];
  int          m_ptr, m_wait;
  logic        m_pause_st;
  logic [31:0] m_addr, m_cnt;
  logic [2:0]  m_src;

  cache_access_scheduler_if #(.NUM_REQ(NR)) bus ();

  cache_access_scheduler #(.NUM_REQ(NR), .MAX_WAIT(MW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pause_i (pause),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] t, input logic [31:0] a);
    bus.req_valid[i]       = v;
    bus.req_type[i*2 +: 2] = t;
    bus.req_addr[i*32 +: 32] = a;
  endtask

  // Reference model evaluated at the falling edge, expected issue checked after the rising edge.
  task automatic step();
    logic       run, anyr, sg, rg;
    logic [3:0] exp_rdy;
    int         gi;
    exp_t       e, got;
    @(negedge clk);
    exp_rdy = '0;
    gi = -1;
    anyr = |bus.req_valid;
    run = rst_n && !pause && !m_pause_st;
    sg = run && bus.snp_valid && ((m_wait < MW) || !anyr);
    rg = run && !sg && anyr;
    if (rg) begin
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (m_ptr + k) % NR;
        if (gi < 0 && bus.req_valid[j]) gi = j;
      end
      exp_rdy[gi] = 1'b1;
    end
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    chk("snp_ready", 64'(bus.snp_ready), 64'(sg));
    e.v = 1'b0; e.t = 2'b11;
    if (!rst_n) begin
      m_ptr = 0; m_wait = 0; m_pause_st = 1'b0; m_addr = '0; m_src = '0; m_cnt = '0;
    end else begin
      if (sg) begin
        e.v = 1'b1; e.t = 2'b10; m_addr = bus.snp_addr; m_src = 3'(NR);
        if (anyr && m_wait < MW) m_wait++;
      end else if (rg) begin
        if (bus.req_type[gi*2 +: 2] != 2'b11) begin
          e.v = 1'b1; e.t = bus.req_type[gi*2 +: 2];
          m_addr = bus.req_addr[gi*32 +: 32]; m_src = 3'(gi);
        end
        m_ptr = (gi + 1) % NR;
        m_wait = 0;
      end
      if (e.v) m_cnt++;
      m_pause_st = pause;
    end
    e.a = m_addr; e.s = m_src; e.c = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'(1), 64'(0));
    end else begin
      got = sb.pop_front();
      chk("issue_valid", 64'(bus.issue_valid), 64'(got.v));
      chk("Access_type", 64'(bus.Access_type), 64'(got.t));
      chk("Hex_address", 64'(bus.Hex_address), 64'(got.a));
      chk("issue_src", 64'(bus.issue_src), 64'(got.s));
      chk("issue_count", 64'(bus.issue_count), 64'(got.c));
    end
  endtask

  initial begin
    int          n_snp, n_r2;
    logic [31:0] saved;
    logic [2:0]  src_seq [5];
    logic [2:0]  exp_seq [5];
    exp_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    m_ptr = 0; m_wait = 0; m_pause_st = 1'b0; m_addr = '0; m_src = '0; m_cnt = '0;
    bus.snp_valid = 1'b0;
    bus.snp_addr  = '0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 2'd0, 32'(i * 'h100));

    // reset with all requesters asserting
    rst_n = 1'b0;
    step();
    step();
    chk("rst_count", 64'(bus.issue_count), 64'(0));
    chk("rst_type", 64'(bus.Access_type), 64'(3));

    // round-robin with all requesters pending
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      src_seq[n] = bus.issue_src;
    end
    for (int n = 0; n < 5; n++) chk("rr_seq", 64'(src_seq[n]), 64'(exp_seq[n]));
    chk("rr_count", 64'(bus.issue_count), 64'(5));

    // continuous snoop versus one requester: anti-starvation after MAX_WAIT
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 2'd1, 32'(i * 'h100));
    set_req(2, 1'b1, 2'd1, 32'h0000_2240);
    bus.snp_valid = 1'b1;
    bus.snp_addr  = 32'h0000_5A00;
    n_snp = 0; n_r2 = 0;
    for (int n = 0; n < 9; n++) begin
      step();
      if (bus.issue_valid && bus.issue_src == 3'd4) n_snp++;
      if (bus.issue_valid && bus.issue_src == 3'd2) n_r2++;
    end
    chk("snp_issues", 64'(n_snp), 64'(8));
    chk("req2_issues", 64'(n_r2), 64'(1));
    step();
    chk("snp_after_clear", 64'(bus.issue_src), 64'(4));

    // pause on the third cycle, then resume
    bus.snp_valid = 1'b0;
    set_req(2, 1'b0, 2'd0, 32'h0);
    set_req(0, 1'b1, 2'd0, 32'h0000_0A00);
    set_req(1, 1'b1, 2'd2, 32'h0000_0B00);
    step();
    step();
    pause = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("pause_ready", 64'(bus.req_ready), 64'(0));
    end
    pause = 1'b0;
    for (int n = 0; n < 3; n++) step();

    // illegal access type is consumed but not issued
    set_req(0, 1'b0, 2'd0, 32'h0);
    set_req(1, 1'b1, 2'd3, 32'h0000_0C00);
    saved = bus.issue_count;
    step();
    chk("illegal_valid", 64'(bus.issue_valid), 64'(0));
    chk("illegal_count", 64'(bus.issue_count), 64'(saved));
    set_req(1, 1'b0, 2'd0, 32'h0);
    step();

    // reset asserted on the same edge as a would-be grant
    set_req(0, 1'b1, 2'd1, 32'hDEAD_BEEC);
    rst_n = 1'b0;
    step();
    chk("midrst_type", 64'(bus.Access_type), 64'(3));
    chk("midrst_count", 64'(bus.issue_count), 64'(0));
    rst_n = 1'b1;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
